// File: rtl/video_out_pipe.sv
// video_out_pipe: registered VGA sync/colour output stage with a timing delay line
// and a video enable that only takes effect at frame boundaries.
module video_out_pipe #(
  parameter int COLOR_BITS   = 1,
  parameter int DATA_LATENCY = 0,
  parameter bit HSYNC_POL    = 1'b0,
  parameter bit VSYNC_POL    = 1'b0
) (
  input  logic                  pixel_clock,
  input  logic                  reset,
  input  logic [COLOR_BITS-1:0] vga_red_data,
  input  logic [COLOR_BITS-1:0] vga_green_data,
  input  logic [COLOR_BITS-1:0] vga_blue_data,
  input  logic                  h_synch,
  input  logic                  v_synch,
  input  logic                  blank,
  input  logic                  video_enable,
  output logic                  VGA_HSYNCH,
  output logic                  VGA_VSYNCH,
  output logic [COLOR_BITS-1:0] VGA_OUT_RED,
  output logic [COLOR_BITS-1:0] VGA_OUT_GREEN,
  output logic [COLOR_BITS-1:0] VGA_OUT_BLUE,
  output logic                  video_active,
  output logic [7:0]            frame_count
);
  logic dl_h, dl_v, dl_b;
  if (DATA_LATENCY == 0) begin : g_nodly
    assign {dl_h, dl_v, dl_b} = {h_synch, v_synch, blank};
  end else begin : g_dly
    logic [2:0] sr_q [DATA_LATENCY];
    always_ff @(posedge pixel_clock) begin
      if (reset) begin
        for (int i = 0; i < DATA_LATENCY; i++) sr_q[i] <= 3'b001;
      end else begin
        sr_q[0] <= {h_synch, v_synch, blank};
        for (int i = 1; i < DATA_LATENCY; i++) sr_q[i] <= sr_q[i-1];
      end
    end
    assign {dl_h, dl_v, dl_b} = sr_q[DATA_LATENCY-1];
  end
  logic                  prev_v_q, active_q, active_d, hs_q, vs_q, frame_start, show;
  logic [7:0]            fc_q, fc_d;
  logic [COLOR_BITS-1:0] r_q, g_q, b_q;
  // gating uses the registered enable, so a new value applies one cycle after frame start
  always_comb begin
    frame_start = dl_v & ~prev_v_q;
    show        = ~dl_b & active_q;
    active_d    = frame_start ? video_enable : active_q;
    fc_d        = fc_q + {7'd0, frame_start};
  end
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      prev_v_q <= 1'b0;
      active_q <= 1'b0;
      fc_q     <= '0;
      hs_q     <= ~HSYNC_POL;
      vs_q     <= ~VSYNC_POL;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
    end else begin
      prev_v_q <= dl_v;
      active_q <= active_d;
      fc_q     <= fc_d;
      hs_q     <= dl_h ? HSYNC_POL : ~HSYNC_POL;
      vs_q     <= dl_v ? VSYNC_POL : ~VSYNC_POL;
      r_q      <= show ? vga_red_data : '0;
      g_q      <= show ? vga_green_data : '0;
      b_q      <= show ? vga_blue_data : '0;
    end
  end
  assign VGA_HSYNCH    = hs_q;
  assign VGA_VSYNCH    = vs_q;
  assign VGA_OUT_RED   = r_q;
  assign VGA_OUT_GREEN = g_q;
  assign VGA_OUT_BLUE  = b_q;
  assign video_active  = active_q;
  assign frame_count   = fc_q;
endmodule
